simple_processor_p: RTL and testbench

Parametrised multi-cycle simple processor: next generation of the 9-bit four-state processor core. Fetches an instruction word from `DIN` when `Run` is high, executes register moves, immediate loads, and a widened ALU op set over a shared `Bus`, and pulses `Done` on completion. Adds configurable data width and register count, logic ops, a conditional move, and Z/C status flags. Sits at the top of the processor datapath and is driven directly by the testbench or instruction source.

---
 rtl/simple_processor_pkg.sv | 34 +++
 rtl/simple_processor_alu.sv | 36 +++
 rtl/simple_processor_p.sv | 153 +++++++++++++++
 tb/tb_simple_processor_p.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/simple_processor_pkg.sv
// Shared encodings for the multi-cycle processor: opcodes, FSM states and
// the bus source select.
package simple_processor_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MVI  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_MVNZ = 3'b111;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    BUS_DIN = 2'd0,
    BUS_RX  = 2'd1,
    BUS_RY  = 2'd2,
    BUS_G   = 2'd3
  } bus_sel_e;

  // True for opcodes that take the T1 -> T2 -> T3 ALU path.
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/simple_processor_alu.sv
// Combinational ALU: add/sub with carry/borrow out, bitwise logic ops,
// zero flag on the truncated result.
module simple_processor_alu
  import simple_processor_pkg::*;
#(
  parameter int DATA_W = 9
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              c
);

  logic [DATA_W:0] ext;

  // The extra MSB carries the add carry-out, or the borrow on sub
  // (set exactly when a < b unsigned); logic ops leave it clear.
  always_comb begin
    ext = '0;
    case (op)
      OP_ADD:  ext = {1'b0, a} + {1'b0, b};
      OP_SUB:  ext = {1'b0, a} - {1'b0, b};
      OP_AND:  ext = {1'b0, a & b};
      OP_OR:   ext = {1'b0, a | b};
      OP_XOR:  ext = {1'b0, a ^ b};
      default: ext = {1'b0, b};
    endcase
  end

  assign result = ext[DATA_W-1:0];
  assign c      = ext[DATA_W];
  assign z      = (ext[DATA_W-1:0] == '0);

endmodule

// File: rtl/simple_processor_p.sv
// Multi-cycle processor top: FSM, instruction register, register file,
// A/G operand registers and the shared Bus mux.
//
//   state | meaning
//   T0    | fetch: Bus = DIN, IR loads when Run is high
//   T1    | mv/mvnz/mvi write Rx and finish; ALU ops latch A <= Rx
//   T2    | G <= A op Ry, flags update
//   T3    | Rx <= G, finish
module simple_processor_p
  import simple_processor_pkg::*;
#(
  parameter int DATA_W = 9,
  parameter int REG_AW = 3
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] Bus,
  output logic              Done,
  output logic [1:0]        Flags
);

  localparam int NREG = 2**REG_AW;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   g_q, g_d;
  logic [1:0]          flags_q, flags_d;
  logic [DATA_W-1:0]   regs_q [NREG];
  logic [DATA_W-1:0]   regs_d [NREG];

  logic [2:0]          opcode;
  logic [REG_AW-1:0]   rx;
  logic [REG_AW-1:0]   ry;
  bus_sel_e            bus_sel;
  logic [NREG-1:0]     reg_we;
  logic                done_raw;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_z;
  logic                alu_c;

  // Instruction fields are MSB-aligned; any spare LSBs are ignored.
  assign opcode = ir_q[DATA_W-1 -: 3];
  assign rx     = ir_q[DATA_W-4 -: REG_AW];
  assign ry     = ir_q[DATA_W-4-REG_AW -: REG_AW];

  simple_processor_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (a_q),
    .b      (Bus),
    .op     (opcode),
    .result (alu_result),
    .z      (alu_z),
    .c      (alu_c)
  );

  always_comb begin
    bus_sel = BUS_DIN;
    case (state_q)
      T0: bus_sel = BUS_DIN;
      T1: begin
        if (opcode == OP_MVI)                           bus_sel = BUS_DIN;
        else if (opcode == OP_MV || opcode == OP_MVNZ)  bus_sel = BUS_RY;
        else                                            bus_sel = BUS_RX;
      end
      T2: bus_sel = BUS_RY;
      T3: bus_sel = BUS_G;
      default: bus_sel = BUS_DIN;
    endcase
  end

  // DIN is gated during reset so the observed bus reads zero.
  always_comb begin
    Bus = '0;
    case (bus_sel)
      BUS_DIN: Bus = Reset ? '0 : DIN;
      BUS_RX:  Bus = regs_q[rx];
      BUS_RY:  Bus = regs_q[ry];
      BUS_G:   Bus = g_q;
      default: Bus = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    a_d      = a_q;
    g_d      = g_q;
    flags_d  = flags_q;
    reg_we   = '0;
    done_raw = 1'b0;
    case (state_q)
      T0: begin
        if (Run) begin
          ir_d    = Bus;
          state_d = T1;
        end
      end
      T1: begin
        if (is_alu_op(opcode)) begin
          a_d     = Bus;
          state_d = T2;
        end else begin
          if (opcode != OP_MVNZ || g_q != '0) reg_we[rx] = 1'b1;
          done_raw = 1'b1;
          state_d  = T0;
        end
      end
      T2: begin
        g_d     = alu_result;
        flags_d = {alu_z, alu_c};
        state_d = T3;
      end
      T3: begin
        reg_we[rx] = 1'b1;
        done_raw   = 1'b1;
        state_d    = T0;
      end
      default: state_d = T0;
    endcase
  end

  // Every register write takes its value from the Bus of the finishing cycle.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (reg_we[i]) regs_d[i] = Bus;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= T0;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
      flags_q <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      g_q     <= g_d;
      flags_q <= flags_d;
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign Done  = done_raw & ~Reset;
  assign Flags = flags_q;

endmodule

// File: tb/tb_simple_processor_p.sv
// Scoreboard bench: the driver models each instruction and queues the
// expected Done-cycle Bus/Flags; a negedge monitor pops and compares.
module tb_simple_processor_p;

  localparam int DW = 9;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [DW-1:0] din;
  logic [DW-1:0] bus;
  logic          done;
  logic [1:0]    flags;

  simple_processor_p #(.DATA_W(DW), .REG_AW(AW)) dut (
    .Clock (clk),
    .Reset (rst),
    .Run   (run),
    .DIN   (din),
    .Bus   (bus),
    .Done  (done),
    .Flags (flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] bus;
    logic [1:0]    flags;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference architectural state.
  int m_r[8];
  int m_g;
  int m_fl;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] enc(input int op, input int rx, input int ry);
    logic [DW-1:0] w;
    w = {op[2:0], rx[2:0], ry[2:0]};
    return w;
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done bus=%0h required=no Done pulse (t=%0t)", bus, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("done_bus", int'(bus), int'(mon_e.bus));
        chk("done_flags", int'(flags), int'(mon_e.flags));
      end
    end
  end

  // Apply the instruction to the reference state; queue the Done-cycle view.
  task automatic model(input int op, input int rx, input int ry, input int imm,
                       output int lat);
    exp_t e;
    int a, b, s, c;
    lat = 1;
    e.bus = '0;
    case (op)
      0: begin e.bus = m_r[ry][DW-1:0]; m_r[rx] = m_r[ry]; end
      3: begin e.bus = imm[DW-1:0]; m_r[rx] = imm % 512; end
      7: begin e.bus = m_r[ry][DW-1:0]; if (m_g != 0) m_r[rx] = m_r[ry]; end
      default: begin
        a = m_r[rx];
        b = m_r[ry];
        c = 0;
        case (op)
          1: begin s = a + b; c = (s >= 512) ? 1 : 0; end
          2: begin s = a - b + 512; c = (a < b) ? 1 : 0; end
          4: s = a & b;
          5: s = a | b;
          default: s = a ^ b;
        endcase
        s = s % 512;
        m_g = s;
        m_fl = ((s == 0) ? 2 : 0) + c;
        m_r[rx] = s;
        e.bus = s[DW-1:0];
        lat = 3;
      end
    endcase
    e.flags = m_fl[1:0];
    sb.push_back(e);
  endtask

  // Entered at posedge+1 of a T0 cycle; returns at posedge+1 of the next T0.
  task automatic issue(input int op, input int rx, input int ry, input int imm = 0);
    int lat, exp_lat;
    model(op, rx, ry, imm, exp_lat);
    run = 1'b1;
    din = enc(op, rx, ry);
    @(posedge clk); #1;
    lat = 1;
    run = 1'($urandom_range(0, 1));
    din = (op == 3) ? imm[DW-1:0] : DW'($urandom);
    while (done !== 1'b1 && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (done !== 1'b1) begin
        run = 1'($urandom_range(0, 1));
        din = DW'($urandom);
      end
    end
    chk("latency", lat, exp_lat);
    @(posedge clk); #1;
    run = 1'b0;
    din = DW'($urandom);
  endtask

  task automatic readback(input int k);
    issue(0, k, k);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      din = DW'($urandom);
      #1;
      chk("idle_bus", int'(bus), int'(din));
      chk("idle_done", int'(done), 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    run = 1'b0;
    repeat (n) begin
      din = DW'($urandom) | DW'(1);
      #1;
      chk("rst_bus", int'(bus), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_flags", int'(flags), 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) m_r[i] = 0;
    m_g = 0;
    m_fl = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    run = 1'b0;
    din = '0;
    @(posedge clk); #1;
    do_reset(2);
    idle(5);
    for (int k = 0; k < 8; k++) readback(k);

    issue(3, 0, 0, 'h1CF);
    issue(0, 5, 0);
    readback(5);

    issue(3, 1, 0, 'h1FF);
    issue(3, 2, 0, 'h001);
    issue(1, 1, 2);

    issue(3, 3, 0, 'h005);
    issue(3, 4, 0, 'h007);
    issue(2, 3, 4);
    issue(6, 4, 4);

    issue(7, 6, 0);
    readback(6);
    issue(1, 5, 2);
    issue(7, 6, 0);
    readback(6);

    // Abort an add in T2; nothing may be written and no Done may appear.
    issue(3, 1, 0, 'h003);
    issue(3, 2, 0, 'h004);
    run = 1'b1;
    din = enc(1, 1, 2);
    @(posedge clk); #1;
    run = 1'b0;
    din = DW'($urandom);
    @(posedge clk); #1;
    chk("t2_done", int'(done), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    do_reset(1);
    readback(1);
    readback(2);
    issue(3, 1, 0, 'h009);
    issue(1, 1, 1);
    readback(1);
    issue(2, 1, 1);

    repeat (150) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 511)));
    end
    for (int k = 0; k < 8; k++) readback(k);

    @(posedge clk); #1;
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
